fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the instruction buffer entries and the maximum number of outstanding requests.
REQ-003 SHALL have port clk  input  1  rising-edge clock (one clock domain).
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports stall_from_ld_2clk_i, stall_from_ld_1clk_i  input  1 each  load-use stall from downstream; hold the output.
REQ-006 SHALL have port flush  input  1  redirect request from execute.
REQ-007 SHALL have port redirect_pc_i  input  32  redirect target, valid when flush=1.
REQ-008 SHALL have ports imem_req_o  output  1, imem_addr_o  output  32, imem_gnt_i  input  1  request handshake; a request transfers when req&gnt.
REQ-009 SHALL have ports imem_rvalid_i  input  1, imem_rdata_i  input  32  in-order responses, at least 1 cycle after grant.
REQ-010 SHALL have ports pc_o  output  32, inst_o  output  32, valid_o  output  1  fetched PC/instruction to the fetch2decode register.

Function
- REQ-011 SHALL run a 2-state FSM: BOOT after reset deassertion (no request, 1 cycle) -> RUN; RUN persists until reset.
- REQ-012 SHALL hold fetch PC fpc; in RUN it SHALL drive imem_req_o=1 and imem_addr_o=fpc when outstanding+occupancy < BUF_DEPTH, else imem_req_o=0.
- REQ-013 SHALL increment fpc by 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) on each req&gnt.
- REQ-014 SHALL keep imem_addr_o stable while imem_req_o=1 and gnt=0, unless flush occurs.
- REQ-015 SHALL track outstanding requests with a counter: +1 on req&gnt, -1 on rvalid, unchanged when both occur.
- REQ-016 SHALL tag each issued request with a 1-bit epoch held in a BUF_DEPTH-deep tag queue.
- REQ-017 SHALL write a response into the buffer only if its tag equals the current epoch; otherwise it SHALL drop the response (the outstanding counter still decrements).
- REQ-018 SHALL store {pc, inst} per buffer entry and drive valid_o=1 when the buffer is non-empty and flush=0; pc_o/inst_o show the head entry.
- REQ-019 SHALL pop the head when valid_o=1 and neither stall input is 1; while stalled, the head SHALL stay unchanged.
- REQ-020 SHALL, on flush, in the same cycle: force valid_o=0 and imem_req_o=0; at the clock edge, empty the buffer, toggle the epoch, and load fpc<=redirect_pc_i.
- REQ-021 SHALL give flush priority over stall, pop and response write in the same cycle.
- REQ-022 SHALL, when the buffer is full, still accept a response in the same cycle as a pop; the request limit in REQ-012 SHALL prevent overflow.
- REQ-023 SHALL show the first instruction on valid_o no earlier than 1 cycle after rvalid, giving registered-output latency of gnt->valid_o >= 2 cycles.
- REQ-024 SHALL drive pc_o=0 and inst_o=32'h0000_0013 (NOP) whenever valid_o=0.

Reset
- REQ-025 SHALL, while rst_n=0, asynchronously set: FSM=BOOT, fpc=RESET_PC, epoch=0, outstanding=0, buffer empty, imem_req_o=0, imem_addr_o=RESET_PC, valid_o=0, pc_o=0, inst_o=NOP.
- REQ-026 SHALL discard any response for a request issued before a mid-operation reset.

Configuration
- REQ-027 SHALL, with FETCH_ALIGN_CHECK_EN defined, add output misalign_o (1 bit), registered; it pulses 1 for one cycle after a flush whose redirect_pc_i[1:0]!=0, and fpc is loaded with redirect_pc_i & ~32'h3.
- REQ-028 SHALL, without FETCH_ALIGN_CHECK_EN, omit misalign_o and load redirect_pc_i unmodified.

Verification
- REQ-029 Reset release, gnt=1, 1-cycle response latency -> first request addr 0x0 in cycle 2, then 0x4, 0x8; valid_o with pc_o=0x0 two cycles after first grant.
- REQ-030 Hold stall_from_ld_1clk_i=1 for 3 cycles with 2 entries buffered -> pc_o/inst_o unchanged, imem_req_o=0, no entry lost after release.
- REQ-031 flush with redirect_pc_i=0x100 while 2 requests are outstanding -> both late responses dropped, next request addr 0x100, first valid pc_o=0x100.
- REQ-032 gnt held 0 for 4 cycles -> imem_addr_o stable at 0x8, fpc not advanced.
- REQ-033 flush and stall_from_ld_2clk_i asserted in the same cycle -> buffer emptied, valid_o=0, fetch resumes at the target.
- REQ-034 With FETCH_ALIGN_CHECK_EN: flush with redirect_pc_i=0x102 -> misalign_o=1 for one cycle, next request addr 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order imem requests, drops stale responses by epoch,
// and buffers {pc, inst} pairs for decode. Define FETCH_ALIGN_CHECK_EN to add misalign_o.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_from_ld_2clk_i,
    input  logic        stall_from_ld_1clk_i,
    input  logic        flush,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int              PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int              CW       = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0]     NOP      = 32'h0000_0013;
    localparam logic [PW-1:0]   LAST_IDX = PW'(BUF_DEPTH - 1);
    localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(BUF_DEPTH);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic            epoch_q;
    logic [CW-1:0]   outstanding_q, outstanding_d;

    logic [PW-1:0]   tagWrPtr_q, tagRdPtr_q;
    logic            tagEpoch_q [BUF_DEPTH];
    logic [31:0]     tagPc_q    [BUF_DEPTH];

    logic [PW-1:0]   bufWrPtr_q, bufWrPtr_d;
    logic [PW-1:0]   bufRdPtr_q, bufRdPtr_d;
    logic [CW-1:0]   bufCnt_q, bufCnt_d;
    logic [31:0]     bufPc_q    [BUF_DEPTH];
    logic [31:0]     bufInst_q  [BUF_DEPTH];

    logic            issue;
    logic            respValid;
    logic            respKeep;
    logic            pop;
    logic            inFlightOk;
    logic [CW:0]     inFlight;
    logic [31:0]     redirectTarget;

    function automatic logic [PW-1:0] nextIdx(input logic [PW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // Requests in flight plus buffered entries never exceed the buffer, so a response always has room.
    assign inFlight   = {1'b0, outstanding_q} + {1'b0, bufCnt_q};
    assign inFlightOk = inFlight < DEPTH_W;

    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     imem_req_o = ~flush & inFlightOk;
            default: state_d = BOOT;
        endcase
    end

    assign imem_addr_o = fpc_q;
    assign issue       = imem_req_o & imem_gnt_i;

    // A response with nothing outstanding belongs to a request from before the last reset.
    assign respValid = imem_rvalid_i & (outstanding_q != '0);
    assign respKeep  = respValid & ~flush & (tagEpoch_q[tagRdPtr_q] == epoch_q);

    assign valid_o = (bufCnt_q != '0) & ~flush;
    assign pop     = valid_o & ~stall_from_ld_1clk_i & ~stall_from_ld_2clk_i;
    assign pc_o    = valid_o ? bufPc_q[bufRdPtr_q]   : '0;
    assign inst_o  = valid_o ? bufInst_q[bufRdPtr_q] : NOP;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    assign redirectTarget = redirect_pc_i & ~32'h0000_0003;
    assign misalign_o     = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= flush & (redirect_pc_i[1:0] != 2'b00);
        end
    end
`else
    assign redirectTarget = redirect_pc_i;
`endif

    always_comb begin
        fpc_d = fpc_q;
        if (flush) begin
            fpc_d = redirectTarget;
        end else if (issue) begin
            fpc_d = fpc_q + 32'd4;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !respValid) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!issue && respValid) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_comb begin
        bufWrPtr_d = bufWrPtr_q;
        bufRdPtr_d = bufRdPtr_q;
        bufCnt_d   = bufCnt_q;
        if (flush) begin
            bufWrPtr_d = '0;
            bufRdPtr_d = '0;
            bufCnt_d   = '0;
        end else begin
            if (respKeep) begin
                bufWrPtr_d = nextIdx(bufWrPtr_q);
            end
            if (pop) begin
                bufRdPtr_d = nextIdx(bufRdPtr_q);
            end
            case ({respKeep, pop})
                2'b10:   bufCnt_d = bufCnt_q + 1'b1;
                2'b01:   bufCnt_d = bufCnt_q - 1'b1;
                default: bufCnt_d = bufCnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fpc_q         <= RESET_PC;
            epoch_q       <= 1'b0;
            outstanding_q <= '0;
            tagWrPtr_q    <= '0;
            tagRdPtr_q    <= '0;
            bufWrPtr_q    <= '0;
            bufRdPtr_q    <= '0;
            bufCnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            outstanding_q <= outstanding_d;
            bufWrPtr_q    <= bufWrPtr_d;
            bufRdPtr_q    <= bufRdPtr_d;
            bufCnt_q      <= bufCnt_d;
            if (flush) begin
                epoch_q <= ~epoch_q;
            end
            if (issue) begin
                tagWrPtr_q <= nextIdx(tagWrPtr_q);
            end
            if (respValid) begin
                tagRdPtr_q <= nextIdx(tagRdPtr_q);
            end
        end
    end

    // Storage arrays carry no reset; pointers and counters alone decide what is live.
    always_ff @(posedge clk) begin
        if (issue) begin
            tagEpoch_q[tagWrPtr_q] <= epoch_q;
            tagPc_q[tagWrPtr_q]    <= fpc_q;
        end
        if (respKeep) begin
            bufPc_q[bufWrPtr_q]   <= tagPc_q[tagRdPtr_q];
            bufInst_q[bufWrPtr_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; each row drives one cycle and checks that cycle's outputs.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] MIS_TARGET = 32'h0000_0100;
`else
    localparam logic [31:0] MIS_TARGET = 32'h0000_0102;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall2 = 1'b0;
    logic        stall1 = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt = 1'b0;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = '0;
    logic [31:0] pcOut;
    logic [31:0] instOut;
    logic        validOut;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        s1;
        logic        s2;
        logic        flush;
        logic [31:0] redirect;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInst;
    } vec_t;

    vec_t vecs [15];

    fetch_unit dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stall_from_ld_2clk_i (stall2),
        .stall_from_ld_1clk_i (stall1),
        .flush                (flush),
        .redirect_pc_i        (redirectPc),
        .imem_req_o           (imemReq),
        .imem_addr_o          (imemAddr),
        .imem_gnt_i           (imemGnt),
        .imem_rvalid_i        (imemRvalid),
        .imem_rdata_i         (imemRdata),
        .pc_o                 (pcOut),
        .inst_o               (instOut),
        .valid_o              (validOut)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_o           (misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                input logic s1, input logic s2, input logic fl, input logic [31:0] redir,
                                input logic expReq, input logic [31:0] expAddr, input logic expValid,
                                input logic [31:0] expPc, input logic [31:0] expInst);
        vec_t v;
        v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
        v.s1 = s1; v.s2 = s2; v.flush = fl; v.redirect = redir;
        v.expReq = expReq; v.expAddr = expAddr; v.expValid = expValid;
        v.expPc = expPc; v.expInst = expInst;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        imemGnt    = v.gnt;
        imemRvalid = v.rvalid;
        imemRdata  = v.rdata;
        stall1     = v.s1;
        stall2     = v.s2;
        flush      = v.flush;
        redirectPc = v.redirect;
        #1;
    endtask

    task automatic runRow(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput($sformatf("%s req", name),   {31'd0, imemReq},  {31'd0, v.expReq});
        checkOutput($sformatf("%s addr", name),  imemAddr,          v.expAddr);
        checkOutput($sformatf("%s valid", name), {31'd0, validOut}, {31'd0, v.expValid});
        checkOutput($sformatf("%s pc", name),    pcOut,             v.expPc);
        checkOutput($sformatf("%s inst", name),  instOut,           v.expInst);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous reset values, releases just after a rising edge.
    task automatic doReset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = '0;
        stall1 = 1'b0; stall2 = 1'b0; flush = 1'b0; redirectPc = '0;
        #1;
        checkOutput($sformatf("%s req", name),   {31'd0, imemReq},  32'd0);
        checkOutput($sformatf("%s addr", name),  imemAddr,          32'd0);
        checkOutput($sformatf("%s valid", name), {31'd0, validOut}, 32'd0);
        checkOutput($sformatf("%s pc", name),    pcOut,             32'd0);
        checkOutput($sformatf("%s inst", name),  instOut,           NOP);
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput($sformatf("%s misalign", name), {31'd0, misalign}, 32'd0);
`endif
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        // Startup, streaming with 1-cycle response latency, then a 3-cycle stall on a full buffer.
        vecs[0]  = mk(1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h00, 0, 32'h00, NOP);
        vecs[1]  = mk(1, 0, 32'h0,         0, 0, 0, 0, 1, 32'h00, 0, 32'h00, NOP);
        vecs[2]  = mk(1, 1, 32'hA000_0000, 0, 0, 0, 0, 1, 32'h04, 0, 32'h00, NOP);
        vecs[3]  = mk(1, 1, 32'hA000_0004, 0, 0, 0, 0, 0, 32'h08, 1, 32'h00, 32'hA000_0000);
        vecs[4]  = mk(1, 0, 32'h0,         0, 0, 0, 0, 1, 32'h08, 1, 32'h04, 32'hA000_0004);
        vecs[5]  = mk(1, 1, 32'hA000_0008, 0, 0, 0, 0, 1, 32'h0C, 0, 32'h00, NOP);
        vecs[6]  = mk(1, 1, 32'hA000_000C, 1, 0, 0, 0, 0, 32'h10, 1, 32'h08, 32'hA000_0008);
        vecs[7]  = mk(1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h10, 1, 32'h08, 32'hA000_0008);
        vecs[8]  = mk(1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h10, 1, 32'h08, 32'hA000_0008);
        vecs[9]  = mk(1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h10, 1, 32'h08, 32'hA000_0008);
        vecs[10] = mk(1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h10, 1, 32'h08, 32'hA000_0008);
        vecs[11] = mk(1, 0, 32'h0,         0, 0, 0, 0, 1, 32'h10, 1, 32'h0C, 32'hA000_000C);
        vecs[12] = mk(1, 1, 32'hA000_0010, 0, 0, 0, 0, 1, 32'h14, 0, 32'h00, NOP);
        vecs[13] = mk(0, 1, 32'hA000_0014, 0, 0, 0, 0, 0, 32'h18, 1, 32'h10, 32'hA000_0010);
        vecs[14] = mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h18, 1, 32'h14, 32'hA000_0014);

        doReset("reset0");
        for (int i = 0; i < 15; i++) begin
            runRow(vecs[i], $sformatf("stream%0d", i));
        end

        // Grant withheld for four cycles: address parks at 0x8.
        doReset("resetA");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h00, 0, 32'h00, NOP), "gntA1");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0, 1, 32'h00, 0, 32'h00, NOP), "gntA2");
        runRow(mk(1, 1, 32'hA000_0000, 0, 0, 0, 0, 1, 32'h04, 0, 32'h00, NOP), "gntA3");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h08, 1, 32'h00, 32'hA000_0000), "gntA4");
        runRow(mk(0, 1, 32'hA000_0004, 0, 0, 0, 0, 1, 32'h08, 0, 32'h00, NOP), "gntA5");
        runRow(mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h08, 1, 32'h04, 32'hA000_0004), "gntA6");
        runRow(mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h08, 0, 32'h00, NOP), "gntA7");
        runRow(mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h08, 0, 32'h00, NOP), "gntA8");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0, 1, 32'h08, 0, 32'h00, NOP), "gntA9");
        runRow(mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h0C, 0, 32'h00, NOP), "gntA10");

        // Flush to 0x100 with two requests outstanding: both late responses are dropped.
        doReset("resetB");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0,          0, 32'h000, 0, 32'h000, NOP), "flushB1");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0,          1, 32'h000, 0, 32'h000, NOP), "flushB2");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0,          1, 32'h004, 0, 32'h000, NOP), "flushB3");
        runRow(mk(1, 0, 32'h0,         0, 0, 1, 32'h100,    0, 32'h008, 0, 32'h000, NOP), "flushB4");
        runRow(mk(1, 1, 32'hDEAD_0000, 0, 0, 0, 0,          0, 32'h100, 0, 32'h000, NOP), "flushB5");
        runRow(mk(1, 1, 32'hDEAD_0004, 0, 0, 0, 0,          1, 32'h100, 0, 32'h000, NOP), "flushB6");
        runRow(mk(0, 1, 32'hB000_0100, 0, 0, 0, 0,          1, 32'h104, 0, 32'h000, NOP), "flushB7");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0,          1, 32'h104, 1, 32'h100, 32'hB000_0100), "flushB8");

        // Reset with a request outstanding; its late response must not surface.
        doReset("resetC");
        runRow(mk(0, 1, 32'hDEAD_0104, 0, 0, 0, 0, 0, 32'h00, 0, 32'h00, NOP), "staleC1");
        runRow(mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h00, 0, 32'h00, NOP), "staleC2");
        runRow(mk(0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h00, 0, 32'h00, NOP), "staleC3");

        // Flush and stall in the same cycle with a full buffer.
        doReset("resetD");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0,       0, 32'h000, 0, 32'h000, NOP), "fsD1");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0,       1, 32'h000, 0, 32'h000, NOP), "fsD2");
        runRow(mk(1, 1, 32'hA000_0000, 0, 0, 0, 0,       1, 32'h004, 0, 32'h000, NOP), "fsD3");
        runRow(mk(1, 1, 32'hA000_0004, 0, 1, 0, 0,       0, 32'h008, 1, 32'h000, 32'hA000_0000), "fsD4");
        runRow(mk(1, 0, 32'h0,         0, 1, 1, 32'h200, 0, 32'h008, 0, 32'h000, NOP), "fsD5");
        runRow(mk(1, 0, 32'h0,         0, 0, 0, 0,       1, 32'h200, 0, 32'h000, NOP), "fsD6");
        runRow(mk(0, 1, 32'hC000_0200, 0, 0, 0, 0,       1, 32'h204, 0, 32'h000, NOP), "fsD7");
        runRow(mk(0, 0, 32'h0,         0, 0, 0, 0,       1, 32'h204, 1, 32'h200, 32'hC000_0200), "fsD8");

        // Fetch address wraps from the top of the address space to zero.
        doReset("resetF");
        runRow(mk(0, 0, 32'h0, 0, 0, 0, 0,            0, 32'h0000_0000, 0, 32'h0, NOP), "wrapF1");
        runRow(mk(0, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0000_0000, 0, 32'h0, NOP), "wrapF2");
        runRow(mk(1, 0, 32'h0, 0, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, 32'h0, NOP), "wrapF3");
        runRow(mk(0, 0, 32'h0, 0, 0, 0, 0,            1, 32'h0000_0000, 0, 32'h0, NOP), "wrapF4");

        // Misaligned redirect: aligned (or passed through) target, one-cycle misalign pulse.
        doReset("resetE");
        runRow(mk(0, 0, 32'h0, 0, 0, 0, 0,          0, 32'h0, 0, 32'h0, NOP), "misE1");
        runRow(mk(0, 0, 32'h0, 0, 0, 1, 32'h102,    0, 32'h0, 0, 32'h0, NOP), "misE2");
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("misE2 misalign", {31'd0, misalign}, 32'd0);
`endif
        runRow(mk(0, 0, 32'h0, 0, 0, 0, 0,          1, MIS_TARGET, 0, 32'h0, NOP), "misE3");
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("misE3 misalign", {31'd0, misalign}, 32'd1);
`endif
        runRow(mk(0, 0, 32'h0, 0, 0, 0, 0,          1, MIS_TARGET, 0, 32'h0, NOP), "misE4");
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("misE4 misalign", {31'd0, misalign}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
